// File: rtl/output_logic_pkg.sv
// rtl/output_logic_pkg.sv - shared state encodings and header constants for the router channel stages
package output_logic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam int HDR_SIZE_LSB = 0;
    localparam int HDR_SIZE_MSB = 5;
    localparam int HDR_ADDR_LSB = 6;
    localparam int HDR_ADDR_MSB = 7;

    localparam int HDR_OVERHEAD = 2;
    localparam int CRC_OVERHEAD = 1;

    // Bytes on the wire for a packet whose header size field is `size`.
    function automatic int pkt_len(input int size, input logic crc);
        return size + HDR_OVERHEAD + (crc ? CRC_OVERHEAD : 0);
    endfunction

endpackage

// File: rtl/output_logic.sv
// rtl/output_logic.sv - drains a channel FIFO and sends whole packets on a byte-wide req/ack link
module output_logic
    import output_logic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 6,
    parameter int LVL_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic [LVL_WIDTH-1:0]  fifo_level,
    output logic                  fifo_pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_req,
    input  logic                  data_out_ack,
    input  logic                  crc_en,
    input  logic                  tx_en,
    output logic                  pkt_done
);

    localparam int CNT_W = DATA_SIZE + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_crc;

    logic [LVL_WIDTH-1:0] w_len;
    logic                 w_start;

    // Length is taken from the FWFT head byte, which is the header while IDLE.
    assign w_len   = LVL_WIDTH'(pkt_len(int'(fifo_data[HDR_SIZE_LSB +: DATA_SIZE]), crc_en));
    assign w_start = tx_en && !fifo_empty && (fifo_level >= w_len);

    assign fifo_pop = (r_state == LOAD) && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_crc        <= 1'b0;
            data_out     <= '0;
            data_out_req <= 1'b0;
            pkt_done     <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_cnt   <= CNT_W'(w_len);
                        r_crc   <= crc_en;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!fifo_empty) begin
                        data_out     <= fifo_data;
                        data_out_req <= 1'b1;
                        r_state      <= SEND;
                    end
                end
                SEND: begin
                    if (data_out_ack) begin
                        data_out_req <= 1'b0;
                        r_cnt        <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            pkt_done <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Remaining count can never exceed the longest packet allowed by the latched CRC mode.
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == LOAD) |-> (int'(r_cnt) <= pkt_len((1 << DATA_SIZE) - 1, r_crc)));

endmodule

// File: tb/tb_output_logic.sv
// tb/tb_output_logic.sv - randomized self-checking bench for output_logic
module tb_output_logic;

    localparam int DW = 8;
    localparam int DS = 6;
    localparam int LW = 7;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          fifo_pop;
    logic [DW-1:0] data_out;
    logic          data_out_req;
    logic          data_out_ack;
    logic          crc_en;
    logic          tx_en;
    logic          pkt_done;

    output_logic #(.DATA_WIDTH(DW), .DATA_SIZE(DS), .LVL_WIDTH(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_level   (fifo_level),
        .fifo_pop     (fifo_pop),
        .data_out     (data_out),
        .data_out_req (data_out_req),
        .data_out_ack (data_out_ack),
        .crc_en       (crc_en),
        .tx_en        (tx_en),
        .pkt_done     (pkt_done)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    bq_t  q;
    bq_t  sent;
    bq_t  rx_q;
    int   acc_cyc[$];
    int   done_cnt = 0;
    int   pop_cnt = 0;
    int   stable_err = 0;
    int   cyc = 0;
    int   ack_delay = 0;
    bit   stray_ack = 1'b0;
    logic pop_s = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void refresh();
        fifo_empty = (q.size() == 0);
        fifo_level = LW'(q.size());
        fifo_data  = (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        sent.push_back(b);
        refresh();
    endtask

    task automatic clear_obs();
        rx_q.delete();
        acc_cyc.delete();
        sent.delete();
        done_cnt   = 0;
        pop_cnt    = 0;
        stable_err = 0;
    endtask

    // Reference: walk the pushed byte stream packet by packet; only complete packets go out.
    function automatic int model(input bq_t b, input bit crc, output int nbytes);
        int idx = 0;
        int np  = 0;
        int n;
        while (idx < b.size()) begin
            n = int'(b[idx][DS-1:0]) + 2 + int'(crc);
            if (idx + n > b.size()) break;
            idx += n;
            np++;
        end
        nbytes = idx;
        return np;
    endfunction

    task automatic wait_done(input int n, input int budget, input string tag);
        int c = 0;
        while (done_cnt < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_wait"}, done_cnt, n);
        repeat (3) @(negedge clk);
    endtask

    task automatic verify(input string tag, input bit crc);
        int nb;
        int np;
        int bad = 0;
        np = model(sent, crc, nb);
        check({tag, "_pkts"}, done_cnt, np);
        check({tag, "_len"}, rx_q.size(), nb);
        for (int i = 0; i < nb && i < rx_q.size(); i++)
            if (rx_q[i] !== sent[i]) bad++;
        check({tag, "_data_bad"}, bad, 0);
    endtask

    // FIFO model: a pop seen before the edge takes effect just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && pop_s && q.size() > 0) void'(q.pop_front());
            pop_s = 1'b0;
            refresh();
        end
    end

    // Receiver and monitors.
    initial begin
        int           wait_cnt = 0;
        logic [7:0]   held = 8'h00;
        data_out_ack = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            data_out_ack = 1'b0;
            pop_s = fifo_pop;
            if (!rst_n) begin
                wait_cnt = 0;
            end else begin
                if (fifo_pop) pop_cnt++;
                if (pkt_done) done_cnt++;
                if (data_out_req) begin
                    if (wait_cnt == 0) held = data_out;
                    else if (data_out !== held) stable_err++;
                    if (wait_cnt >= ack_delay) begin
                        data_out_ack = 1'b1;
                        rx_q.push_back(data_out);
                        acc_cyc.push_back(cyc);
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    if (stray_ack) data_out_ack = 1'b1;
                    wait_cnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad;
        int   viol;
        int   c;
        bit   crc;
        int   sz;
        rst_n  = 1'b0;
        tx_en  = 1'b0;
        crc_en = 1'b0;
        refresh();
        repeat (3) @(negedge clk);
        check("rst_req", data_out_req, 0);
        check("rst_data", data_out, 0);
        check("rst_done", pkt_done, 0);
        check("rst_pop", fifo_pop, 0);
        rst_n = 1'b1;

        // Basic 5-byte packet, immediate ack.
        clear_obs();
        tx_en = 1'b1;
        @(negedge clk);
        push(8'h83); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_done(1, 100, "t1");
        verify("t1", 1'b0);
        check("t1_first", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h83);
        check("t1_pops", pop_cnt, 5);
        bad = 0;
        for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 2) bad++;
        check("t1_gap", bad, 0);

        // Level check: size 5 needs 7 bytes before starting.
        clear_obs();
        viol = 0;
        @(negedge clk);
        push(8'h05); push(8'hA1); push(8'hA2);
        repeat (4) begin
            @(negedge clk);
            viol += int'(data_out_req | fifo_pop);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            viol += int'(data_out_req | fifo_pop);
            push(8'hB0 + 8'(i));
        end
        @(negedge clk);
        viol += int'(data_out_req | fifo_pop);
        push(8'hC7);
        check("t2_early", viol, 0);
        @(negedge clk);
        check("t2_start_pop", fifo_pop, 1);
        wait_done(1, 100, "t2");
        verify("t2", 1'b0);

        // CRC mode: 3-byte packet, no start at level 2.
        clear_obs();
        crc_en = 1'b1;
        @(negedge clk);
        push(8'h40); push(8'hAA);
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            viol += int'(data_out_req | fifo_pop);
        end
        check("t3_early", viol, 0);
        push(8'h5C);
        wait_done(1, 100, "t3");
        verify("t3", 1'b1);
        crc_en = 1'b0;

        // Slow ack plus stray acks while req is low.
        clear_obs();
        ack_delay = 10;
        stray_ack = 1'b1;
        @(negedge clk);
        push(8'h02); push(8'h61); push(8'h62); push(8'h63);
        wait_done(1, 200, "t4");
        verify("t4", 1'b0);
        check("t4_stable", stable_err, 0);
        bad = 0;
        for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 12) bad++;
        check("t4_gap", bad, 0);
        ack_delay = 0;
        stray_ack = 1'b0;

        // tx_en gating: only one packet starts from a one-cycle enable.
        clear_obs();
        tx_en = 1'b0;
        @(negedge clk);
        push(8'h01); push(8'hD1); push(8'hD2);
        push(8'h00); push(8'hE1);
        repeat (10) @(negedge clk);
        check("t5_idle_rx", rx_q.size(), 0);
        check("t5_idle_pop", pop_cnt, 0);
        tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        wait_done(1, 100, "t5");
        repeat (20) @(negedge clk);
        check("t5_pkts", done_cnt, 1);
        check("t5_len", rx_q.size(), 3);
        check("t5_last", (rx_q.size() == 3) ? rx_q[2] : 8'hxx, 8'hD2);
        check("t5_left", q.size(), 2);

        // Reset during byte 3 of a 6-byte packet.
        q.delete();
        refresh();
        clear_obs();
        ack_delay = 3;
        tx_en = 1'b1;
        @(negedge clk);
        push(8'h04); push(8'h71); push(8'h72); push(8'h73); push(8'h74); push(8'h75);
        c = 0;
        while (!(rx_q.size() == 2 && data_out_req) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("t6_reach", rx_q.size(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_req", data_out_req, 0);
        check("t6_pop", fifo_pop, 0);
        check("t6_done", pkt_done, 0);
        check("t6_data", data_out, 0);
        q.delete();
        refresh();
        repeat (2) @(negedge clk);
        clear_obs();
        rst_n = 1'b1;
        ack_delay = 0;
        @(negedge clk);
        push(8'h81); push(8'hC1); push(8'hD2);
        wait_done(1, 100, "t6");
        verify("t6", 1'b0);

        // Randomized batches.
        for (int b = 0; b < 8; b++) begin
            clear_obs();
            crc       = 1'($urandom_range(0, 1));
            crc_en    = crc;
            ack_delay = int'($urandom_range(0, 3));
            stray_ack = 1'($urandom_range(0, 1));
            for (int p = 0; p < 3; p++) begin
                sz = int'($urandom_range(0, 7));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push({2'($urandom), 6'(sz)});
                for (int k = 0; k < sz + 1 + int'(crc); k++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    push(8'($urandom));
                end
            end
            wait_done(3, 3000, "rnd");
            verify("rnd", crc);
            check("rnd_drained", q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/output_logic.md
Name: output_logic

Overview:
- Transmit-side counterpart of the router's input stage: drains one channel FIFO and sends whole packets on a byte-wide req/ack output interface.
- Starts a packet only when all of its bytes are already in the FIFO, so it never stalls mid-packet and never sends a partial packet.
- The FIFO is first-word-fall-through; the head byte is visible on fifo_data without popping.
- One instance per output channel, between the channel FIFO and the channel pins.

Parameters:
DATA_WIDTH, 8, byte width of FIFO and output data.
DATA_SIZE, 6, width of the header size field (header bits [DATA_SIZE-1:0]).
LVL_WIDTH, 7, width of the FIFO occupancy input; must hold 2^DATA_SIZE+2.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
fifo_data  in  DATA_WIDTH  FIFO head byte (FWFT).
fifo_empty  in  1  FIFO empty.
fifo_level  in  LVL_WIDTH  number of bytes currently in the FIFO.
fifo_pop  out  1  pop the head byte this cycle.
data_out  out  DATA_WIDTH  output byte, registered.
data_out_req  out  1  data_out valid, registered.
data_out_ack  in  1  receiver accepts the byte (1-cycle pulse).
crc_en  in  1  packets carry a trailing CRC byte.
tx_en  in  1  channel enable; sampled only in IDLE.
pkt_done  out  1  1-cycle pulse after the last byte of a packet is acked.

Behaviour:
- Reset values: data_out 0, data_out_req 0, pkt_done 0, fifo_pop 0, state IDLE, byte counter 0, latched crc flag 0.
- Packet format: header byte H, then SIZE+1 payload bytes, then 1 CRC byte if crc_en. SIZE = H[DATA_SIZE-1:0].
- Total length N = SIZE + 2 + crc_en.
  - N is computed zero-extended to LVL_WIDTH bits; range 2..2^DATA_SIZE+2 (66 at the defaults).
  - The CRC byte is forwarded unchanged; this block does not generate or check CRC.
- States: IDLE, LOAD, SEND.
- IDLE:
  - If tx_en && !fifo_empty && fifo_level >= N (N computed from the head byte and the live crc_en): load the byte counter (DATA_SIZE+1 bits) with N, latch crc_en, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - If !fifo_empty: fifo_pop=1 (combinational), data_out <= fifo_data, data_out_req <= 1, go to SEND.
  - If fifo_empty (cannot happen given the level check): hold in LOAD with no pop and req low.
- SEND:
  - Hold data_out_req and data_out stable until data_out_ack=1.
  - On ack: data_out_req <= 0 and counter decrements.
    - If the counter was 1: pkt_done <= 1 for one cycle, go to IDLE.
    - Else go to LOAD.
- Throughput: at least 2 cycles per byte, because req is low for exactly one cycle (LOAD) between bytes. Between packets there is at least 1 IDLE cycle.
- data_out_ack while data_out_req=0 is ignored and has no effect.
- tx_en deasserting mid-packet is ignored; the packet completes. A change in crc_en mid-packet is ignored (the latched value is used).
- data_out keeps the last byte after a packet ends; only reset clears it.
- Reset mid-packet: all outputs go to reset values immediately (async). Bytes remaining in the FIFO are not consumed; the FIFO shares the same reset.
- Only the byte count is length-checked; the header address field is not examined (routing is done upstream).

Decomposition:
- Shared package:
  - state encodings IDLE/LOAD/SEND (2-bit);
  - header field positions (size LSB/MSB, addr bits);
  - header+CRC overhead constants (2, 1).
- The input stage uses the same header constants.
- No sub-module; a single always-block FSM with a counter. Approximately 150-200 lines.

Test Plan:
- crc_en=0; FIFO holds 0x83,0x11,0x22,0x33,0x44 (level 5); ack 1 cycle after each req.
  -> Bytes 83,11,22,33,44 are sent in order; 5 fifo_pop pulses; 1 pkt_done; req low for 1 cycle between bytes.
- Header size 5 with level 3.
  -> No req and no pop while level rises to 6; transmission starts on the first IDLE cycle with level 7; 7 bytes sent.
- crc_en=1; header 0x40 (size 0), payload 0xAA, CRC 0x5C; level 2, then 3.
  -> No start at level 2; at level 3 sends 40,AA,5C; pkt_done once.
- Ack delayed 10 cycles, plus a stray ack pulse during the LOAD cycle.
  -> data_out and req stay stable for 10 cycles; the stray ack does not decrement the counter and the byte count stays correct.
- tx_en=0 with a full packet queued.
  -> Stays IDLE. Then tx_en=1 for 1 cycle and 0 afterwards.
  -> The whole packet completes; a second queued packet does not start.
- rst_n low during SEND of byte 3 of 6.
  -> req, pop and pkt_done are 0 immediately and data_out is 0. After release with a reset FIFO refilled with a fresh packet, that packet is sent from its header.
